// File: rtl/dp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dp_ctrl_pkg
// Description : Shared encodings for the datapath micro-sequencer: opcodes,
//               register select codes, sequencer states, instruction legality
//               and select-code to one-hot strobe conversion.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package dp_ctrl_pkg;

  // Opcodes
  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_LDI = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  // Register select codes; the code is also the bit index of the register's
  // strobe inside a 4-bit {R0, RB, RA, RZ} strobe vector.
  localparam logic [1:0] SEL_RZ = 2'b00;
  localparam logic [1:0] SEL_RA = 2'b01;
  localparam logic [1:0] SEL_RB = 2'b10;
  localparam logic [1:0] SEL_R0 = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_WAIT = 3'd2,
    S_T2   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // MOV/ADD may only write RB or R0 (RZ belongs to the adder, RA to the
  // immediate path); a MOV onto itself is rejected as well.
  function automatic logic instr_legal(input logic [1:0] op,
                                       input logic [1:0] dst,
                                       input logic [1:0] src);
    logic ok;
    ok = 1'b1;
    if ((op == OP_MOV || op == OP_ADD) && (dst == SEL_RZ || dst == SEL_RA))
      ok = 1'b0;
    if (op == OP_MOV && src == dst)
      ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [3:0] sel_onehot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage : dp_ctrl_pkg
`default_nettype wire

// File: rtl/dp_strobe_decode.sv
`default_nettype none
// ============================================================================
// Module      : dp_strobe_decode
// Description : Combinational Moore decode of sequencer state plus latched
//               instruction fields into bus-driver and load-enable strobes.
// Ports       : state_i    - current sequencer state
//               op_i       - latched opcode
//               dst_i      - latched destination select
//               src_i      - latched source select
//               out_sel_o  - one-hot bus drivers {R0out, RBout, RAout, RZout}
//               in_sel_o   - one-hot load enables {R0in, RBin, RAin, RZin}
// Revision    : 1.0 - initial release
// ============================================================================
module dp_strobe_decode
  import dp_ctrl_pkg::*;
(
  input  state_t     state_i,
  input  logic [1:0] op_i,
  input  logic [1:0] dst_i,
  input  logic [1:0] src_i,
  output logic [3:0] out_sel_o,
  output logic [3:0] in_sel_o
);

  // Illegal instructions never visit T1/T2, so no legality gating is needed.
  always_comb begin
    out_sel_o = 4'b0000;
    in_sel_o  = 4'b0000;
    case (state_i)
      S_T1: begin
        case (op_i)
          OP_MOV: begin
            out_sel_o = sel_onehot(src_i);
            in_sel_o  = sel_onehot(dst_i);
          end
          OP_ADD: begin
            out_sel_o = sel_onehot(src_i);
            in_sel_o  = sel_onehot(SEL_RZ);
          end
          OP_LDI: begin
            in_sel_o  = sel_onehot(SEL_RA);
          end
          default: begin
          end
        endcase
      end
      S_T2: begin
        // Only ADD reaches T2: adder result onto the bus into the destination.
        out_sel_o = sel_onehot(SEL_RZ);
        in_sel_o  = sel_onehot(dst_i);
      end
      default: begin
      end
    endcase
  end

endmodule : dp_strobe_decode
`default_nettype wire

// File: rtl/dp_micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dp_micro_sequencer
// Description : Accepts one instruction at a time (valid/ready) and steps
//               the register/bus/adder datapath through its micro-steps,
//               ending each instruction with a done or illegal pulse.
// Ports       : clock, clear         - clock, synchronous active-low reset
//               instr_valid/ready    - instruction handshake (ready in IDLE)
//               instr_op/dst/src/imm - instruction fields
//               imm_out              - latched immediate to RA immediate input
//               RZout..R0out         - bus driver selects
//               RZin..R0in           - register load enables
//               busy, done, illegal  - status
// Revision    : 1.0 - initial release
// ============================================================================
module dp_micro_sequencer
  import dp_ctrl_pkg::*;
#(
  parameter int ADD_WAIT = 0,
  parameter int IMM_W    = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [1:0]       instr_op,
  input  logic [1:0]       instr_dst,
  input  logic [1:0]       instr_src,
  input  logic [IMM_W-1:0] instr_imm,
  output logic [IMM_W-1:0] imm_out,
  output logic             RZout,
  output logic             RAout,
  output logic             RBout,
  output logic             R0out,
  output logic             RZin,
  output logic             RAin,
  output logic             RBin,
  output logic             R0in,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  // Settling delay held in the 3-bit wait counter (valid range 0..7).
  localparam logic [2:0] c_WAIT_LOAD = 3'(ADD_WAIT);

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       dst_q, dst_d;
  logic [1:0]       src_q, src_d;
  logic [IMM_W-1:0] imm_q, imm_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             ill_q, ill_d;
  logic             legal_w;
  logic [3:0]       out_sel_w;
  logic [3:0]       in_sel_w;

  assign legal_w = instr_legal(instr_op, instr_dst, instr_src);

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      dst_q   <= 2'b00;
      src_q   <= 2'b00;
      imm_q   <= '0;
      cnt_q   <= 3'd0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      imm_q   <= imm_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dst_d   = dst_q;
    src_d   = src_q;
    imm_d   = imm_q;
    cnt_d   = cnt_q;
    ill_d   = ill_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          op_d    = instr_op;
          dst_d   = instr_dst;
          src_d   = instr_src;
          imm_d   = instr_imm;
          ill_d   = ~legal_w;
          // Rejected instructions skip straight to DONE to pulse illegal.
          state_d = legal_w ? S_T1 : S_DONE;
        end
      end
      S_T1: begin
        if (op_q == OP_ADD) begin
          if (c_WAIT_LOAD == 3'd0) begin
            state_d = S_T2;
          end else begin
            state_d = S_WAIT;
            cnt_d   = c_WAIT_LOAD;
          end
        end else begin
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        // Counter spends exactly c_WAIT_LOAD cycles here, reaching 0 on exit.
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1)
          state_d = S_T2;
      end
      S_T2:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  dp_strobe_decode u_strobe_decode (
    .state_i   (state_q),
    .op_i      (op_q),
    .dst_i     (dst_q),
    .src_i     (src_q),
    .out_sel_o (out_sel_w),
    .in_sel_o  (in_sel_w)
  );

  assign RZout = out_sel_w[SEL_RZ];
  assign RAout = out_sel_w[SEL_RA];
  assign RBout = out_sel_w[SEL_RB];
  assign R0out = out_sel_w[SEL_R0];
  assign RZin  = in_sel_w[SEL_RZ];
  assign RAin  = in_sel_w[SEL_RA];
  assign RBin  = in_sel_w[SEL_RB];
  assign R0in  = in_sel_w[SEL_R0];

  assign instr_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE) && !ill_q;
  assign illegal     = (state_q == S_DONE) &&  ill_q;
  assign imm_out     = imm_q;

endmodule : dp_micro_sequencer
`default_nettype wire

// File: tb/tb_dp_micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dp_micro_sequencer
// Description : Self-checking bench for dp_micro_sequencer (ADD_WAIT=2).
//               Each instruction is expanded into its expected per-cycle
//               output trace and compared cycle by cycle.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dp_micro_sequencer;

  localparam int ADD_WAIT = 2;
  localparam int IMM_W    = 8;

  logic             clock = 1'b0;
  logic             clear;
  logic             instr_valid;
  logic             instr_ready;
  logic [1:0]       instr_op, instr_dst, instr_src;
  logic [IMM_W-1:0] instr_imm;
  logic [IMM_W-1:0] imm_out;
  logic             RZout, RAout, RBout, R0out;
  logic             RZin, RAin, RBin, R0in;
  logic             busy, done, illegal;

  int               n_total = 0;
  int               n_bad   = 0;
  logic [IMM_W-1:0] model_imm;

  always #5 clock = ~clock;

  dp_micro_sequencer #(.ADD_WAIT(ADD_WAIT), .IMM_W(IMM_W)) dut (
    .clock       (clock),
    .clear       (clear),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_dst   (instr_dst),
    .instr_src   (instr_src),
    .instr_imm   (instr_imm),
    .imm_out     (imm_out),
    .RZout       (RZout),
    .RAout       (RAout),
    .RBout       (RBout),
    .R0out       (R0out),
    .RZin        (RZin),
    .RAin        (RAin),
    .RBin        (RBin),
    .R0in        (R0in),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Vector layout: {ready, busy, done, illegal, outs[R0,RB,RA,RZ], ins[R0,RB,RA,RZ]}
  function automatic logic [11:0] obs_vec();
    return {instr_ready, busy, done, illegal,
            R0out, RBout, RAout, RZout, R0in, RBin, RAin, RZin};
  endfunction

  function automatic logic [11:0] mk(input logic rdy, input logic bsy, input logic dn,
                                     input logic ill, input logic [3:0] outs,
                                     input logic [3:0] ins);
    return {rdy, bsy, dn, ill, outs, ins};
  endfunction

  function automatic logic [3:0] oh(input logic [1:0] code);
    logic [3:0] one;
    one = 4'd1;
    return one << code;
  endfunction

  // Run one instruction starting at a negedge in IDLE; ends at the negedge of
  // the following IDLE cycle. With scramble set, inputs are randomized while
  // busy to show they are ignored.
  task automatic run_instr(input logic [1:0] op, input logic [1:0] dst,
                           input logic [1:0] src, input logic [IMM_W-1:0] imm,
                           input bit scramble);
    logic [11:0] tr[$];
    bit          ok;
    ok = 1'b1;
    if ((op == 2'd0 || op == 2'd1) && dst < 2'd2) ok = 1'b0;
    if (op == 2'd0 && src == dst)                 ok = 1'b0;
    if (!ok) begin
      tr.push_back(mk(0, 1, 0, 1, 4'h0, 4'h0));
    end else begin
      case (op)
        2'd0: tr.push_back(mk(0, 1, 0, 0, oh(src), oh(dst)));
        2'd1: begin
          tr.push_back(mk(0, 1, 0, 0, oh(src), oh(2'd0)));
          for (int w = 0; w < ADD_WAIT; w++) tr.push_back(mk(0, 1, 0, 0, 4'h0, 4'h0));
          tr.push_back(mk(0, 1, 0, 0, oh(2'd0), oh(dst)));
        end
        2'd2: tr.push_back(mk(0, 1, 0, 0, 4'h0, oh(2'd1)));
        default: tr.push_back(mk(0, 1, 0, 0, 4'h0, 4'h0));
      endcase
      tr.push_back(mk(0, 1, 1, 0, 4'h0, 4'h0));
    end

    check_eq("idle_vec", 32'(obs_vec()), 32'(mk(1, 0, 0, 0, 4'h0, 4'h0)));
    check_eq("idle_imm", 32'(imm_out), 32'(model_imm));
    instr_valid = 1'b1;
    instr_op    = op;
    instr_dst   = dst;
    instr_src   = src;
    instr_imm   = imm;
    @(posedge clock);
    model_imm = imm;
    foreach (tr[i]) begin
      @(negedge clock);
      check_eq($sformatf("op%0d_d%0d_s%0d_step%0d", op, dst, src, i),
               32'(obs_vec()), 32'(tr[i]));
      check_eq("imm_busy", 32'(imm_out), 32'(model_imm));
      if (scramble) begin
        instr_valid = 1'($urandom);
        instr_op    = 2'($urandom);
        instr_dst   = 2'($urandom);
        instr_src   = 2'($urandom);
        instr_imm   = IMM_W'($urandom);
      end else begin
        instr_valid = 1'b0;
      end
    end
    @(negedge clock);
  endtask

  initial begin
    clear       = 1'b0;
    instr_valid = 1'b0;
    instr_op    = 2'd0;
    instr_dst   = 2'd0;
    instr_src   = 2'd0;
    instr_imm   = '0;
    model_imm   = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("reset_vec", 32'(obs_vec()), 32'(mk(1, 0, 0, 0, 4'h0, 4'h0)));
    check_eq("reset_imm", 32'(imm_out), 32'(0));
    clear = 1'b1;

    run_instr(2'd0, 2'd2, 2'd1, 8'h11, 1'b0);  // MOV RA->RB
    run_instr(2'd1, 2'd3, 2'd2, 8'h22, 1'b0);  // ADD RB->R0
    run_instr(2'd2, 2'd0, 2'd0, 8'hA5, 1'b0);  // LDI A5
    run_instr(2'd3, 2'd1, 2'd1, 8'h33, 1'b0);  // NOP
    run_instr(2'd0, 2'd1, 2'd2, 8'h44, 1'b0);  // MOV dst=RA: illegal
    run_instr(2'd1, 2'd0, 2'd3, 8'h55, 1'b0);  // ADD dst=RZ: illegal
    run_instr(2'd0, 2'd3, 2'd3, 8'h66, 1'b0);  // MOV src==dst: illegal
    run_instr(2'd0, 2'd3, 2'd0, 8'h77, 1'b1);  // back-to-back MOVs, busy noise
    run_instr(2'd0, 2'd2, 2'd3, 8'h88, 1'b1);

    // Reset in the middle of an ADD's wait phase.
    instr_valid = 1'b1;
    instr_op    = 2'd1;
    instr_dst   = 2'd3;
    instr_src   = 2'd2;
    instr_imm   = 8'h99;
    @(posedge clock);
    @(negedge clock);
    check_eq("rst_t1", 32'(obs_vec()), 32'(mk(0, 1, 0, 0, oh(2'd2), oh(2'd0))));
    instr_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check_eq("rst_wait", 32'(obs_vec()), 32'(mk(0, 1, 0, 0, 4'h0, 4'h0)));
    clear = 1'b0;
    @(posedge clock);
    @(negedge clock);
    model_imm = '0;
    check_eq("rst_idle", 32'(obs_vec()), 32'(mk(1, 0, 0, 0, 4'h0, 4'h0)));
    check_eq("rst_imm", 32'(imm_out), 32'(model_imm));
    @(posedge clock);
    @(negedge clock);
    check_eq("rst_nodone", 32'(obs_vec()), 32'(mk(1, 0, 0, 0, 4'h0, 4'h0)));
    clear = 1'b1;
    run_instr(2'd0, 2'd2, 2'd0, 8'h5A, 1'b0);  // fresh MOV after release

    for (int n = 0; n < 80; n++) begin
      run_instr(2'($urandom), 2'($urandom), 2'($urandom), IMM_W'($urandom),
                1'($urandom));
    end

    instr_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_dp_micro_sequencer
`default_nettype wire
